lowampa_beam_scaler: RTL
========================

# lowampa_beam_scaler

Per-beam trigger rate scaler that sits directly downstream of the dual low-amplitude beam/threshold stages. It consumes the concatenated raw `trigger_o` bits of all beam modules and counts rising edges per beam over a programmable gate period. At each period boundary it atomically transfers all counts into a shadow bank. Software reads the shadow bank through a registered address/strobe port, and also uses it as the rate input for threshold servoing.

## Interface
Parameters:
- `NBEAMS`, 48: number of trigger bits (beams × thresholds) concatenated on `trig_i`.
- `CNT_BITS`, 16: width of each per-beam counter and shadow entry.
- `ABITS`, `$clog2(NBEAMS)`: read address width (derived).

Ports (one clock; reset is asynchronous and active-low):
- `clk_i`  in  1  beamforming clock; all logic is synchronous to it.
- `rst_ni`  in  1  asynchronous, active-low reset.
- `trig_i`  in  NBEAMS  raw trigger bits from the threshold stages, synchronous to `clk_i`.
- `enable_i`  in  1  scaler run enable; when low, the timer and counters freeze.
- `period_i`  in  32  gate period in `clk_i` cycles; sampled at each period start; values below 2 are treated as 2.
- `rd_i`  in  1  read strobe.
- `rd_addr_i`  in  ABITS  shadow entry to read.
- `rd_data_o`  out  CNT_BITS  shadow count returned for the strobed address.
- `rd_valid_o`  out  1  one-cycle qualifier for `rd_data_o`.
- `period_done_o`  out  1  one-cycle pulse after each shadow transfer.
- `seq_o`  out  8  period sequence number; increments on each transfer and wraps 255→0.

## Operation
- Edge detect: `trig_q` holds the previous cycle's `trig_i`; `edge = trig_i & ~trig_q`. `trig_q` updates every cycle regardless of `enable_i`, so re-enabling never produces a spurious edge.
- A level held high for N cycles counts once.
- Timer runs from 0 to P−1, where P is the latched `period_i`. The terminal cycle is the cycle in which timer == P−1 and `enable_i` is high.
- Non-terminal enabled cycle: `cnt[b]` increments by `edge[b]`.
- Terminal cycle, all updates on the same clock edge:
  - `shadow[b] <= cnt[b]`. The terminal cycle's own edge is excluded from the shadow.
  - `cnt[b] <= edge[b]`, so an edge in the terminal cycle counts in the new period.
  - Timer returns to 0, `period_i` is re-latched, and `seq_o` increments.
- `enable_i` low: timer, `cnt[]`, shadow and `seq_o` all hold; edges are discarded.
- Counter overflow: see Configuration.
- Readout: `rd_i` is sampled at a clock edge. One cycle later, `rd_valid_o` is 1 and `rd_data_o` is `shadow[rd_addr_i]`.
  - If a transfer lands on the same edge as the read, the read returns the pre-transfer value.
  - `rd_addr_i ≥ NBEAMS` returns 0, with `rd_valid_o` still asserted.
  - Back-to-back reads are allowed: one result per cycle.
- Reset (asserted at any time, including mid-period):
  - `cnt[]`, `shadow[]`, timer, `trig_q` and `seq_o` clear to 0.
  - The latched period becomes 2.
  - `rd_data_o`, `rd_valid_o` and `period_done_o` are 0.
  - Because `trig_q` is 0, the first cycle after release with `trig_i` high counts as an edge.
  - `period_i` is latched on the first enabled cycle after release.

## Timing
- Counter update: 1 cycle after the edge cycle.
- Shadow visible: on the edge ending the terminal cycle.
- `period_done_o`: asserted in the cycle after the transfer edge, width 1.
- Read latency: 1 cycle, fully pipelined.
- Period length: exactly P enabled cycles between consecutive `period_done_o` pulses when `enable_i` stays high.
- Changing `period_i` mid-period takes effect at the next period start only.

## Configuration
- Macro: `SCALER_SATURATE_EN`.
- Defined: counters saturate at 2^CNT_BITS−1 and hold that value until the transfer.
- Undefined: counters wrap modulo 2^CNT_BITS, with no indication.

## Test plan
- Setup: reset, `enable_i`=1, `period_i`=100. Drive `trig_i[3]` high for 50 cycles → after the first `period_done_o`, reading address 3 returns 1 and every other entry returns 0; `seq_o`=1.
- Toggle `trig_i[0]` every cycle (high/low) for a full 100-cycle period → shadow[0]=50; `period_done_o` pulses exactly 100 cycles apart.
- Single edge on `trig_i[5]` in the terminal cycle → shadow[5]=0 for this period and 1 for the next.
- Override `CNT_BITS`=4 and apply 20 edges on beam 7 in one period → 15 with `SCALER_SATURATE_EN` defined, 4 without.
- Drop `enable_i` for 30 cycles mid-period while toggling `trig_i[1]` → those edges are not counted and `period_done_o` is delayed by 30 cycles.
- Assert `rst_ni` low at cycle 60 of a period → all outputs and `seq_o` read 0. Read address 47, then address 48 → data 0 each time with `rd_valid_o`=1 one cycle after the strobe.

Source files
------------

// File: rtl/lowampa_beam_scaler.sv
// -----------------------------------------------------------------------------
// lowampa_beam_scaler
//
// Per-beam trigger rate scaler. This block counts the rising edges of each raw
// trigger bit over a programmable gate period. At the end of each period it
// copies every count into a shadow bank in one step. Software reads the shadow
// bank through a registered address/strobe port.
//
// Build option:
//   SCALER_SATURATE_EN  defined   : counters stop at 2^CNT_BITS-1 until the transfer
//                       undefined : counters wrap modulo 2^CNT_BITS
//
// Ports:
//   clk_i          beamforming clock
//   rst_ni         asynchronous active-low reset
//   trig_i         raw trigger bits, one per beam/threshold
//   enable_i       run enable; when low, the timer, counters, shadow and seq hold
//   period_i       gate period in cycles (values below 2 act as 2); latched at
//                  the first enabled cycle after reset and at every period end
//   rd_i           read strobe
//   rd_addr_i      shadow entry to read (addresses >= NBEAMS read as 0)
//   rd_data_o      shadow count, one cycle after the strobe
//   rd_valid_o     qualifier for rd_data_o
//   period_done_o  one-cycle pulse after each shadow transfer
//   seq_o          period sequence number, wraps 255 -> 0
// -----------------------------------------------------------------------------
module lowampa_beam_scaler #(
  parameter int NBEAMS   = 48,
  parameter int CNT_BITS = 16,
  parameter int ABITS    = $clog2(NBEAMS)
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic [NBEAMS-1:0]   trig_i,
  input  logic                enable_i,
  input  logic [31:0]         period_i,
  input  logic                rd_i,
  input  logic [ABITS-1:0]    rd_addr_i,
  output logic [CNT_BITS-1:0] rd_data_o,
  output logic                rd_valid_o,
  output logic                period_done_o,
  output logic [7:0]          seq_o
);

  localparam logic [31:0]    PERIOD_MIN = 32'd2;
  localparam logic [ABITS:0] NBEAMS_A   = (ABITS+1)'(NBEAMS);
`ifdef SCALER_SATURATE_EN
  localparam logic [CNT_BITS-1:0] CNT_MAX = '1;
`endif

  logic [NBEAMS-1:0]   r_trig_q;
  logic [CNT_BITS-1:0] r_cnt    [NBEAMS];
  logic [CNT_BITS-1:0] r_shadow [NBEAMS];
  logic [31:0]         r_timer;
  logic [31:0]         r_period;
  logic                r_first;     // no enabled cycle has happened since reset
  logic [7:0]          r_seq;
  logic                r_done;
  logic                r_rd_valid;
  logic [CNT_BITS-1:0] r_rd_data;

  logic [NBEAMS-1:0]   w_edge;
  logic [31:0]         w_period_clamped;
  logic                w_terminal;
  logic                w_addr_ok;
  logic [CNT_BITS-1:0] w_cnt_inc [NBEAMS];

  // r_trig_q is updated even when disabled. So re-enabling never sees a stale
  // low level as a new edge.
  assign w_edge           = trig_i & ~r_trig_q;
  assign w_period_clamped = (period_i < PERIOD_MIN) ? PERIOD_MIN : period_i;
  assign w_terminal       = enable_i && (r_timer == r_period - 32'd1);
  assign w_addr_ok        = {1'b0, rd_addr_i} < NBEAMS_A;

  // Next count for a non-terminal enabled cycle.
  always_comb begin
    for (int b = 0; b < NBEAMS; b++) begin
      // NOTE: each combinational output gets a default before any condition,
      // so that no path leaves it unassigned and no latch is inferred.
      w_cnt_inc[b] = r_cnt[b] + CNT_BITS'(w_edge[b]);
`ifdef SCALER_SATURATE_EN
      if (r_cnt[b] == CNT_MAX) begin
        w_cnt_inc[b] = r_cnt[b];
      end
`endif
    end
  end

  // Timer, counters and shadow bank.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_trig_q <= '0;
      r_timer  <= '0;
      r_period <= PERIOD_MIN;
      r_first  <= 1'b1;
      r_seq    <= '0;
      r_done   <= 1'b0;
      // NOTE: the count and shadow arrays are plain registers, not RAM. They
      // are reset because software must read zeros after a reset.
      for (int b = 0; b < NBEAMS; b++) begin
        r_cnt[b]    <= '0;
        r_shadow[b] <= '0;
      end
    end else begin
      // NOTE: all state is updated with non-blocking assignments, so every
      // right-hand side here sees the value from before this edge. This is
      // what keeps the terminal cycle's own edge out of the shadow.
      r_trig_q <= trig_i;
      r_done   <= w_terminal;
      if (enable_i) begin
        r_first <= 1'b0;
        if (w_terminal) begin
          r_timer  <= '0;
          r_period <= w_period_clamped;
          r_seq    <= r_seq + 8'd1;
          for (int b = 0; b < NBEAMS; b++) begin
            r_shadow[b] <= r_cnt[b];
            r_cnt[b]    <= CNT_BITS'(w_edge[b]);   // terminal edge opens the new period
          end
        end else begin
          r_timer <= r_timer + 32'd1;
          if (r_first) begin
            r_period <= w_period_clamped;
          end
          for (int b = 0; b < NBEAMS; b++) begin
            r_cnt[b] <= w_cnt_inc[b];
          end
        end
      end
    end
  end

  // Registered readout. It samples the shadow from before the edge, so a read
  // on the transfer edge returns the previous period's count.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_rd_valid <= 1'b0;
      r_rd_data  <= '0;
    end else begin
      r_rd_valid <= rd_i;
      if (rd_i) begin
        r_rd_data <= w_addr_ok ? r_shadow[rd_addr_i] : '0;
      end
    end
  end

  assign rd_data_o     = r_rd_data;
  assign rd_valid_o    = r_rd_valid;
  assign period_done_o = r_done;
  assign seq_o         = r_seq;

endmodule
